// File: rtl/to_lower_pkg.sv
// rtl/to_lower_pkg.sv - ASCII constants and occupancy state encoding for to_lower_stream
package to_lower_pkg;

  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
  localparam int         CASE_BIT      = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/ascii_to_lower.sv
// rtl/ascii_to_lower.sv - combinational single-byte uppercase-to-lowercase mapper
module ascii_to_lower
  import to_lower_pkg::*;
(
  input  logic [7:0] byte_in,
  input  logic       bypass,
  output logic [7:0] byte_out,
  output logic       changed
);

  logic is_upper;

  // Full 8-bit compare so Latin-1 range 8'hC1..8'hDA is left alone.
  assign is_upper = (byte_in >= ASCII_UPPER_A) && (byte_in <= ASCII_UPPER_Z);
  assign changed  = is_upper & ~bypass;

  always_comb begin
    byte_out           = byte_in;
    byte_out[CASE_BIT] = byte_in[CASE_BIT] | changed;
  end

endmodule

// File: rtl/to_lower_stream.sv
// rtl/to_lower_stream.sv - streaming lowercase converter with output register, skid slot and counters
module to_lower_stream
  import to_lower_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bypass,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_count,
  output logic [CNT_W-1:0] conv_count,
  output logic [CNT_W-1:0] byte_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state_q, state_d;
  logic [7:0] out_q, skid_q;
  logic [7:0] conv_byte;
  logic       conv_changed;
  logic       accept, drain;
  logic       load_out, load_skid, out_from_skid;

  ascii_to_lower u_lower (
    .byte_in  (in_data),
    .bypass   (bypass),
    .byte_out (conv_byte),
    .changed  (conv_changed)
  );

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q == ONE) || (state_q == FULL);
  assign out_data  = out_q;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = ONE;
      ONE: begin
        if (accept && !drain)      state_d = FULL;
        else if (!accept && drain) state_d = EMPTY;
      end
      FULL:    if (drain) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // The skid slot only fills when the out stage is occupied and stalled.
  always_comb begin
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state_q)
      EMPTY: load_out = accept;
      ONE: begin
        load_out  = accept & drain;
        load_skid = accept & ~drain;
      end
      FULL: begin
        load_out      = drain;
        out_from_skid = drain;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= 8'h00;
      skid_q <= 8'h00;
    end else begin
      if (load_out)  out_q  <= out_from_skid ? skid_q : conv_byte;
      if (load_skid) skid_q <= conv_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_count <= '0;
      conv_count <= '0;
    end else if (clr_count) begin
      byte_count <= '0;
      conv_count <= '0;
    end else if (accept) begin
      if (byte_count != CNT_MAX)                 byte_count <= byte_count + CNT_ONE;
      if (conv_changed && conv_count != CNT_MAX) conv_count <= conv_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_to_lower_stream.sv
// tb/tb_to_lower_stream.sv - self-checking bench for to_lower_stream
module tb_to_lower_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid, bypass, out_ready, clr_count;
  logic        in_ready, out_valid;
  logic [7:0]  out_data;
  logic [15:0] conv_count, byte_count;
  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_out_data;
  logic [1:0]  s_conv_count, s_byte_count;

  logic [7:0]  exp_byte;
  logic [7:0]  sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  typedef struct {
    logic [7:0] din;
    logic       byp;
    logic [7:0] dout;
  } vec_t;
  vec_t vecs[21];

  to_lower_stream #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bypass(bypass), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .clr_count(clr_count), .conv_count(conv_count), .byte_count(byte_count)
  );

  to_lower_stream #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
    .bypass(bypass), .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .clr_count(clr_count), .conv_count(s_conv_count), .byte_count(s_byte_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change 1 time unit after a rising edge, so at the falling edge
  // the handshakes seen are exactly those that complete on the next rising edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && in_valid && in_ready) sb.push_back(exp_byte);
    if (out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %02h, no byte outstanding", out_data);
      end else begin
        e = sb.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL out_data: got %02h expected %02h", out_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lower_ref(input logic [7:0] b, input logic byp);
    return (!byp && b >= 8'h41 && b <= 8'h5A) ? b + 8'd32 : b;
  endfunction

  task automatic send(input logic [7:0] b, input logic byp, input logic [7:0] e);
    bit done;
    done = 0;
    in_data = b; bypass = byp; exp_byte = e; in_valid = 1'b1;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: byte %02h never accepted", b);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int t = 0; t < 60 && !done; t++) begin
      if (sb.size() == 0) done = 1;
      else begin @(posedge clk); #2; end
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic pulse_clr();
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
  endtask

  initial begin
    int c0;
    logic [7:0] hello_in[13]  = '{8'h48,8'h65,8'h6c,8'h6c,8'h6f,8'h2c,8'h20,8'h57,8'h4f,8'h52,8'h4c,8'h44,8'h21};
    logic [7:0] hello_out[13] = '{8'h68,8'h65,8'h6c,8'h6c,8'h6f,8'h2c,8'h20,8'h77,8'h6f,8'h72,8'h6c,8'h64,8'h21};
    logic [7:0] bnd_in[6]     = '{8'h40,8'h41,8'h5A,8'h5B,8'h61,8'hC1};
    logic [7:0] bnd_out[6]    = '{8'h40,8'h61,8'h7A,8'h5B,8'h61,8'hC1};
    for (int i = 0; i < 13; i++) vecs[i] = '{hello_in[i], 1'b0, hello_out[i]};
    for (int i = 0; i < 6; i++)  vecs[13+i] = '{bnd_in[i], 1'b0, bnd_out[i]};
    vecs[19] = '{8'h51, 1'b1, 8'h51};
    vecs[20] = '{8'h51, 1'b0, 8'h71};

    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; bypass = 1'b0;
    out_ready = 1'b1; clr_count = 1'b0; exp_byte = 8'h00;
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 8'h00);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_byte_count", byte_count, 0);
    chk("reset_conv_count", conv_count, 0);
    @(posedge clk); #1 rst = 1'b0;

    // "Hello, WORLD!" at full rate
    c0 = cyc;
    for (int i = 0; i < 13; i++) begin
      send(vecs[i].din, vecs[i].byp, vecs[i].dout);
      if (i == 0) begin
        chk("latency_valid", out_valid, 1);
        chk("latency_data", out_data, 8'h68);
      end
    end
    chk("throughput_cycles", cyc - c0, 13);
    wait_drain();
    chk("hello_byte_count", byte_count, 13);
    chk("hello_conv_count", conv_count, 6);

    // range boundaries
    pulse_clr();
    for (int i = 13; i < 19; i++) send(vecs[i].din, vecs[i].byp, vecs[i].dout);
    wait_drain();
    chk("bnd_conv_count", conv_count, 2);
    chk("bnd_byte_count", byte_count, 6);

    // bypass on first 'Q' only
    pulse_clr();
    for (int i = 19; i < 21; i++) send(vecs[i].din, vecs[i].byp, vecs[i].dout);
    wait_drain();
    chk("bypass_conv_count", conv_count, 1);

    // backpressure fills the skid slot
    out_ready = 1'b0;
    send(8'h41, 1'b0, lower_ref(8'h41, 1'b0));
    chk("bp_in_ready_one", in_ready, 1);
    send(8'h42, 1'b0, lower_ref(8'h42, 1'b0));
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_hold_data", out_data, 8'h61);
    fork
      send(8'h43, 1'b0, lower_ref(8'h43, 1'b0));
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_data_late", out_data, 8'h61);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_still_full", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // saturation on the narrow instance, then clear beats accept
    pulse_clr();
    for (int i = 0; i < 5; i++) send(8'h41, 1'b0, lower_ref(8'h41, 1'b0));
    chk("sat_byte_count", s_byte_count, 3);
    chk("sat_conv_count", s_conv_count, 3);
    chk("wide_byte_count", byte_count, 5);
    clr_count = 1'b1;
    send(8'h42, 1'b0, lower_ref(8'h42, 1'b0));
    clr_count = 1'b0;
    chk("clr_s_byte", s_byte_count, 0);
    chk("clr_s_conv", s_conv_count, 0);
    chk("clr_byte", byte_count, 0);
    chk("clr_conv", conv_count, 0);
    wait_drain();

    // asynchronous reset while full
    out_ready = 1'b0;
    send(8'h58, 1'b0, lower_ref(8'h58, 1'b0));
    send(8'h59, 1'b0, lower_ref(8'h59, 1'b0));
    chk("pre_rst_full", in_ready, 0);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_ready", in_ready, 1);
    chk("rst_async_data", out_data, 8'h00);
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_stale_valid", out_valid, 0);
    send(8'h5A, 1'b0, lower_ref(8'h5A, 1'b0));
    wait_drain();
    chk("post_rst_byte_count", byte_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
